// File: rtl/dma_burst_mover.sv
// DMA burst mover: after a channel grant, streams exactly xfer_len beats from the
// DMA read port to the DMA write port through a small circular FIFO.
module dma_burst_mover #(
  parameter int DATA_WIDTH = 128,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  xfer_len,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  beat_count,
  output logic                  dma_req,
  input  logic                  dma_resp,
  input  logic                  dma_read_valid,
  input  logic [DATA_WIDTH-1:0] dma_read_data,
  output logic                  dma_read_ready,
  output logic                  dma_write_valid,
  output logic [DATA_WIDTH-1:0] dma_write_data,
  input  logic                  dma_write_ready
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

  state_t                 state_reg, state_next;
  logic [LEN_WIDTH-1:0]   len_reg;
  logic [LEN_WIDTH-1:0]   rd_cnt_reg;
  logic [LEN_WIDTH-1:0]   wr_cnt_reg;
  logic [PTR_W-1:0]       wr_ptr_reg;
  logic [PTR_W-1:0]       rd_ptr_reg;
  logic [CNT_W-1:0]       occ_reg;
  logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];

  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;
  logic last_pop;

  assign fifo_full  = (occ_reg == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (occ_reg == '0);

  // Ready depends only on registered occupancy, so a full FIFO never accepts
  // even when a pop happens on the same edge.
  assign dma_read_ready  = (state_reg == XFER) && !fifo_full && (rd_cnt_reg < len_reg);
  assign dma_write_valid = !fifo_empty;
  assign dma_write_data  = fifo_empty ? '0 : mem[rd_ptr_reg];
  assign beat_count      = wr_cnt_reg;

  assign push     = dma_read_valid && dma_read_ready;
  assign pop      = dma_write_valid && dma_write_ready;
  assign last_pop = pop && (wr_cnt_reg == len_reg - LEN_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    busy       = (state_reg != IDLE);
    done       = 1'b0;
    dma_req    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = (xfer_len == '0) ? DONE : REQ;
        end
      end
      REQ: begin
        dma_req = 1'b1;
        if (dma_resp) begin
          state_next = XFER;
        end
      end
      XFER: begin
        if (last_pop) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_reg    <= '0;
      rd_cnt_reg <= '0;
      wr_cnt_reg <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      if (state_reg == IDLE && start) begin
        len_reg    <= xfer_len;
        rd_cnt_reg <= '0;
        wr_cnt_reg <= '0;
      end
      if (push) begin
        rd_cnt_reg <= rd_cnt_reg + LEN_WIDTH'(1);
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        wr_cnt_reg <= wr_cnt_reg + LEN_WIDTH'(1);
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   occ_reg <= occ_reg + CNT_W'(1);
        2'b01:   occ_reg <= occ_reg - CNT_W'(1);
        default: occ_reg <= occ_reg;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= dma_read_data;
    end
  end

endmodule

// File: tb/tb_dma_burst_mover.sv
// Directed bench for dma_burst_mover: inputs change on the falling edge,
// outputs are checked on the falling edge after each rising edge.
module tb_dma_burst_mover;

  localparam int DW = 128;
  localparam int FD = 4;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] xfer_len;
  logic          busy;
  logic          done;
  logic [LW-1:0] beat_count;
  logic          dma_req;
  logic          dma_resp;
  logic          dma_read_valid;
  logic [DW-1:0] dma_read_data;
  logic          dma_read_ready;
  logic          dma_write_valid;
  logic [DW-1:0] dma_write_data;
  logic          dma_write_ready;

  dma_burst_mover #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .xfer_len(xfer_len),
    .busy(busy), .done(done), .beat_count(beat_count),
    .dma_req(dma_req), .dma_resp(dma_resp),
    .dma_read_valid(dma_read_valid), .dma_read_data(dma_read_data),
    .dma_read_ready(dma_read_ready),
    .dma_write_valid(dma_write_valid), .dma_write_data(dma_write_data),
    .dma_write_ready(dma_write_ready)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Transfer model state
  int       cur_len;
  logic [7:0] base;
  int       rd_acc;
  int       wr_seen;
  bit       granted;
  int       cyc;
  int       g_cyc;
  int       req_wait;
  int       grant_dly;
  bit       rnd_rd;
  bit       rnd_wr;
  int       stall_left;

  function automatic logic [DW-1:0] beat_val(input int i);
    return {base, 88'h0, 32'(i + 1)};
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: account for handshakes that complete on the coming edge,
  // advance, check outputs against the model, then drive the next inputs.
  task automatic step();
    logic          rd_hs, wr_hs, gr, stall_prev;
    logic [DW-1:0] held;
    rd_hs      = dma_read_valid && dma_read_ready;
    wr_hs      = dma_write_valid && dma_write_ready;
    gr         = dma_req && dma_resp;
    stall_prev = dma_write_valid && !dma_write_ready;
    held       = dma_write_data;
    if (wr_hs) begin
      check("wr_data", dma_write_data, beat_val(wr_seen));
      wr_seen++;
    end
    if (rd_hs) rd_acc++;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (gr) begin
      granted = 1'b1;
      g_cyc   = cyc - 1;
      check("req_drop", dma_req, 1'b0);
    end
    if (wr_hs && wr_seen == cur_len) granted = 1'b0;
    if (stall_prev) check("wr_hold", dma_write_data, held);
    if (granted) begin
      check("rd_ready", dma_read_ready, ((rd_acc - wr_seen) < FD) && (rd_acc < cur_len));
      check("wr_valid", dma_write_valid, rd_acc != wr_seen);
      check("beat_cnt", beat_count, wr_seen);
    end else begin
      check("rd_ready_idle", dma_read_ready, 1'b0);
      check("wr_valid_idle", dma_write_valid, 1'b0);
    end
    if (dma_req) req_wait++; else req_wait = 0;
    dma_resp = dma_req && (req_wait >= grant_dly);
    if (!(dma_read_valid && !dma_read_ready))
      dma_read_valid = rnd_rd ? 1'($urandom_range(0, 1)) : 1'b1;
    dma_read_data = beat_val(rd_acc);
    if (stall_left > 0) begin
      dma_write_ready = 1'b0;
      if (dma_write_valid) stall_left--;
    end else begin
      dma_write_ready = rnd_wr ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  task automatic start_xfer(input int len, input logic [7:0] b);
    cur_len  = len;
    base     = b;
    rd_acc   = 0;
    wr_seen  = 0;
    granted  = 1'b0;
    req_wait = 0;
    dma_read_data = beat_val(0);
    start    = 1'b1;
    xfer_len = LW'(len);
    step();
    start    = 1'b0;
    check("busy_start", busy, 1'b1);
    if (len != 0) begin
      check("req_start", dma_req, 1'b1);
      check("cnt_clear", beat_count, '0);
    end
  endtask

  task automatic run_done(input int max, input bit tput);
    int n = 0;
    while (!done && n < max) begin
      step();
      n++;
    end
    check("done_seen", done, 1'b1);
    check("beats_out", wr_seen, cur_len);
    check("beats_in", rd_acc, cur_len);
    check("beat_count", beat_count, cur_len);
    check("busy_done", busy, 1'b1);
    if (tput) check("latency", cyc - g_cyc, cur_len + 2);
    step();
    check("done_pulse", done, 1'b0);
    check("busy_off", busy, 1'b0);
    check("count_held", beat_count, cur_len);
    $display("[TB] transfer len=%0d beats_out=%0d beat_count=%0d cycles=%0d", cur_len, wr_seen, beat_count, n);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; xfer_len = '0; dma_resp = 1'b0;
    dma_read_valid = 1'b0; dma_read_data = '0; dma_write_ready = 1'b0;
    cur_len = 0; base = 8'h0; rd_acc = 0; wr_seen = 0; granted = 1'b0;
    cyc = 0; g_cyc = 0; req_wait = 0; grant_dly = 2;
    rnd_rd = 1'b0; rnd_wr = 1'b0; stall_left = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_req", dma_req, 1'b0);
    check("rst_rd_ready", dma_read_ready, 1'b0);
    check("rst_wr_valid", dma_write_valid, 1'b0);
    check("rst_wr_data", dma_write_data, '0);
    check("rst_beat_count", beat_count, '0);
    rst = 1'b0;
    step();

    // Basic: 8 beats 0x1..0x8, both sides always ready
    start_xfer(8, 8'h00);
    run_done(60, 1'b1);

    // Write back-pressure: 10 beats, writer stalled for 6 cycles
    start_xfer(10, 8'h10);
    stall_left = 6;
    run_done(80, 1'b0);

    // Zero length: done one cycle after start, no request
    start_xfer(0, 8'h20);
    check("zero_done", done, 1'b1);
    check("zero_req", dma_req, 1'b0);
    check("zero_count", beat_count, '0);
    step();
    check("zero_done_off", done, 1'b0);
    check("zero_busy_off", busy, 1'b0);
    check("zero_req_off", dma_req, 1'b0);

    // Start pulses in REQ and XFER must be ignored
    start_xfer(6, 8'h30);
    start = 1'b1; xfer_len = 16'd2;
    step();
    start = 1'b0;
    for (int i = 0; i < 10 && !granted; i++) step();
    start = 1'b1; xfer_len = 16'd3;
    step();
    start = 1'b0;
    run_done(60, 1'b0);

    // Random stalls on both streams, 100 beats
    rnd_rd = 1'b1; rnd_wr = 1'b1; grant_dly = 1;
    start_xfer(100, 8'h40);
    run_done(3000, 1'b0);
    rnd_rd = 1'b0; rnd_wr = 1'b0; grant_dly = 2;

    // Reset after 3 of 8 beats, then a fresh 4-beat transfer
    start_xfer(8, 8'h50);
    for (int i = 0; i < 60 && wr_seen < 3; i++) step();
    check("pre_rst_beats", wr_seen, 3);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_req", dma_req, 1'b0);
    check("mid_rst_rd_ready", dma_read_ready, 1'b0);
    check("mid_rst_wr_valid", dma_write_valid, 1'b0);
    check("mid_rst_wr_data", dma_write_data, '0);
    check("mid_rst_count", beat_count, '0);
    rst = 1'b0;
    granted = 1'b0; rd_acc = 0; wr_seen = 0; cur_len = 0;
    dma_resp = 1'b0;
    step();
    start_xfer(4, 8'h60);
    run_done(60, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dma_burst_mover.md
# dma_burst_mover

Parametrised DMA data mover for the NPU datapath: on a software-issued `start`, it requests the DMA channel, then moves exactly `xfer_len` beats from the DMA read stream to the DMA write stream through an internal FIFO. It then pulses `done`. It sits between the DMA read and write ports, adds bounded buffering, back-pressure handling and transfer-length control, and replaces the fixed one-register pass-through.

## Interface
- `DATA_WIDTH`, 128: beat width in bits on both streams.
- `FIFO_DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `LEN_WIDTH`, 16: width of the transfer-length and beat counters.
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a transfer; sampled only in IDLE.
- `xfer_len`  in  LEN_WIDTH  number of beats; sampled together with `start`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at transfer end.
- `beat_count`  out  LEN_WIDTH  beats written so far in the current or last transfer.
- `dma_req`  out  1  channel request.
- `dma_resp`  in  1  channel grant.
- `dma_read_valid`  in  1  read-stream beat valid.
- `dma_read_data`  in  DATA_WIDTH  read-stream beat.
- `dma_read_ready`  out  1  read-stream accept.
- `dma_write_valid`  out  1  write-stream beat valid.
- `dma_write_data`  out  DATA_WIDTH  write-stream beat.
- `dma_write_ready`  in  1  write-stream accept.

## Operation
**States:** IDLE, REQ, XFER, DONE.
- **IDLE**
  - `start` with `xfer_len` ≠ 0: latch the length, clear both counters, go to REQ.
  - `start` with `xfer_len` = 0: go directly to DONE. No request is made and no beats move.
- **REQ**
  - `dma_req` is 1.
  - When `dma_resp` = 1, go to XFER. `dma_req` drops in the same edge.
- **XFER**
  - Read acceptance: `dma_read_ready` = !fifo_full && (rd_cnt < len).
  - Push: a push occurs on `dma_read_valid` && `dma_read_ready`, and rd_cnt increments.
  - Pop: a pop occurs on `dma_write_valid` && `dma_write_ready`, and wr_cnt and `beat_count` increment.
  - When the final pop happens (wr_cnt reaches len), go to DONE.
- **DONE**
  - `done` = 1 for exactly one cycle, then go to IDLE.
  - `beat_count` holds its value until the next accepted `start`.

**FIFO**
- Circular buffer of FIFO_DEPTH entries with an occupancy counter of width log2(FIFO_DEPTH)+1.
- Pointers wrap modulo FIFO_DEPTH.
- Push and pop in the same cycle leave occupancy unchanged.
- A push never happens while full, even if a pop occurs that cycle, because ready is computed from registered occupancy.
- A pop never happens while empty.

**Stream outputs**
- `dma_write_valid` = !fifo_empty.
- `dma_write_data` = FIFO head.
- While `dma_write_valid` is 1 and `dma_write_ready` is 0, `dma_write_data` is held stable.
- Data are passed unmodified and in order.

**Other rules**
- `start` in any state other than IDLE is ignored.
- Counters are LEN_WIDTH wide and never wrap, because they are bounded by len.
- Reset in any state:
  - FIFO contents are discarded.
  - State returns to IDLE.
  - In-flight beats are lost; no `done` pulse is produced.

## Timing
**Reset values**
- `dma_req`, `dma_read_ready`, `dma_write_valid`, `busy`, `done`: 0.
- `dma_write_data`: 0.
- `beat_count`: 0.
- Internal pointers and counters: 0.

**Outputs**
- All outputs are functions of registers only; there is no combinational path from any input to any output.

**Latency**
- `start` at edge N: `busy` and `dma_req` are high from cycle N+1.
- Grant at edge M: first `dma_read_ready` at cycle M+1.
- A beat pushed at edge K is visible on `dma_write_valid`/`dma_write_data` at cycle K+1.
- With an idle FIFO, read-to-write latency is 1 cycle.
- Final pop at edge P: `done` is high at cycle P+1, and `busy` falls at cycle P+2.
- Zero-length transfer: `start` at N gives `done` at N+1.

**Throughput and handshakes**
- Steady state is 1 beat/cycle when both streams are always ready.
- The valid/ready handshake follows the usual rule: a beat transfers on the edge where both are high.
- `dma_write_valid` does not drop until its beat is taken.

## Test plan
- **Basic transfer:** `xfer_len`=8, grant 2 cycles after `dma_req`, both streams always ready, data 0x1..0x8.
  - Write stream shows 0x1..0x8 in order, 1 beat/cycle after the 1-cycle fill.
  - `done` pulses once; `beat_count`=8.
- **Write back-pressure:** `DATA_WIDTH`=128, `FIFO_DEPTH`=4, `xfer_len`=10, `dma_write_ready` held 0 for 6 cycles.
  - `dma_read_ready` drops after 4 accepted beats.
  - `dma_write_data` is stable while stalled.
  - All 10 beats arrive in order; no beat is lost or duplicated.
- **Random stalls:** `xfer_len`=100 with random valid/ready on both sides.
  - Scoreboard matches exactly 100 beats.
  - `dma_read_ready` is never high once rd_cnt reaches 100.
- **Zero length:** `start` with `xfer_len`=0.
  - `dma_req` never asserts.
  - `done` is high 1 cycle after `start`; `beat_count`=0.
- **Start ignored while busy:** `start` pulsed in REQ and in XFER.
  - No effect; the original length completes.
- **Reset mid-transfer:** `rst` asserted after 3 of 8 beats.
  - Next cycle: all outputs are at reset values and the FIFO is empty.
  - A new 4-beat transfer then completes correctly.
